// File: rtl/fp16_add_issue_if.sv
// Operand/result streams and external adder hookup for fp16_add_issue.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; a producer holding valid keeps its payload stable until
// that edge, and ready never depends combinationally on valid.
interface fp16_add_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;

  // Environment side: feeds operands, consumes results, models the adder.
  modport master (
    output in_valid, in_a, in_b, add_x, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_result, out_flags
  );

  // Issue stage side.
  modport slave (
    input  in_valid, in_a, in_b, add_x, out_ready,
    output in_ready, add_a, add_b, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp16_add_issue.sv
// fp16 add issue/exception stage: classifies operand pairs, sends same-sign
// finite normal pairs through the external registered adder, resolves the
// rest locally, and returns results in order through S1 -> T -> O.
module fp16_add_issue (
  input  logic              clk,
  input  logic              rst,
  fp16_add_issue_if.slave   bus
);

  localparam logic [15:0] QNAN = 16'h7E00;

  // Stage S1
  logic        s1_valid;
  logic [15:0] s1_a, s1_b, s1_res;
  logic        s1_add;
  logic [3:0]  s1_flags;
  // Stage T (pair is inside the external adder)
  logic        t_valid;
  logic [15:0] t_a, t_b, t_res;
  logic        t_add;
  logic [3:0]  t_flags;
  // Stage O
  logic        o_valid;
  logic [15:0] o_res;
  logic [3:0]  o_flags;

  // Pipeline control
  logic o_free, t_adv, t_free, s1_adv, in_ready_w;

  // Classification results for the pair presented on the input
  logic        a_sub, b_sub, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [15:0] ca, cb, c_res;
  logic        c_add;
  logic [3:0]  c_flags;

  // Adder overflow handling at O load
  logic [15:0] t_out_res;
  logic [3:0]  t_out_flags;

  assign o_free     = ~o_valid | bus.out_ready;
  assign t_adv      = t_valid & o_free;
  assign t_free     = ~t_valid | t_adv;
  assign s1_adv     = s1_valid & t_free;
  assign in_ready_w = ~s1_valid | s1_adv;

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = o_valid;
  assign bus.out_result = o_res;
  assign bus.out_flags  = o_flags;

  // A stalled T re-presents its own operands so the adder (which has no
  // enable) recaptures them and add_x stays valid for that entry.
  assign bus.add_a = (t_valid & ~t_adv) ? t_a : s1_a;
  assign bus.add_b = (t_valid & ~t_adv) ? t_b : s1_b;

  // Classify the incoming pair; earlier checks take precedence.
  always_comb begin
    a_sub  = (bus.in_a[14:10] == 5'd0) && (bus.in_a[9:0] != 10'd0);
    b_sub  = (bus.in_b[14:10] == 5'd0) && (bus.in_b[9:0] != 10'd0);
    ca     = a_sub ? {bus.in_a[15], 15'h0} : bus.in_a;
    cb     = b_sub ? {bus.in_b[15], 15'h0} : bus.in_b;
    a_nan  = (ca[14:10] == 5'h1F) && (ca[9:0] != 10'd0);
    b_nan  = (cb[14:10] == 5'h1F) && (cb[9:0] != 10'd0);
    a_inf  = (ca[14:10] == 5'h1F) && (ca[9:0] == 10'd0);
    b_inf  = (cb[14:10] == 5'h1F) && (cb[9:0] == 10'd0);
    a_zero = (ca[14:0] == 15'd0);
    b_zero = (cb[14:0] == 15'd0);
    c_add   = 1'b0;
    c_res   = 16'h0000;
    c_flags = {a_sub | b_sub, 3'b000};
    if (a_nan | b_nan) begin
      c_res      = QNAN;
      c_flags[0] = 1'b1;
    end else if (a_inf & b_inf) begin
      if (ca[15] == cb[15]) begin
        c_res = ca;
      end else begin
        c_res      = QNAN;
        c_flags[0] = 1'b1;
      end
    end else if (a_inf) begin
      c_res = ca;
    end else if (b_inf) begin
      c_res = cb;
    end else if (a_zero & b_zero) begin
      c_res = {ca[15] & cb[15], 15'h0};
    end else if (a_zero) begin
      c_res = cb;
    end else if (b_zero) begin
      c_res = ca;
    end else if (ca[15] != cb[15]) begin
      c_res      = QNAN;
      c_flags[2] = 1'b1;
    end else begin
      c_add = 1'b1;
    end
  end

  // Select what T hands to O: adder sum (saturated to inf on overflow) or bypass.
  always_comb begin
    t_out_res   = t_res;
    t_out_flags = t_flags;
    if (t_add) begin
      if (bus.add_x[14:10] == 5'h1F) begin
        t_out_res      = {bus.add_x[15], 5'h1F, 10'h000};
        t_out_flags[1] = 1'b1;
      end else begin
        t_out_res = bus.add_x;
      end
    end
  end

  // S1 register: loads a classified pair whenever it has room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= 16'h0;
      s1_b     <= 16'h0;
      s1_res   <= 16'h0;
      s1_add   <= 1'b0;
      s1_flags <= 4'h0;
    end else if (in_ready_w) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a     <= ca;
        s1_b     <= cb;
        s1_res   <= c_res;
        s1_add   <= c_add;
        s1_flags <= c_flags;
      end
    end
  end

  // T register: mirrors the adder's capture of S1 operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_valid <= 1'b0;
      t_a     <= 16'h0;
      t_b     <= 16'h0;
      t_res   <= 16'h0;
      t_add   <= 1'b0;
      t_flags <= 4'h0;
    end else if (t_free) begin
      t_valid <= s1_valid;
      if (s1_adv) begin
        t_a     <= s1_a;
        t_b     <= s1_b;
        t_res   <= s1_res;
        t_add   <= s1_add;
        t_flags <= s1_flags;
      end
    end
  end

  // O register: holds result and flags stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_res   <= 16'h0;
      o_flags <= 4'h0;
    end else if (o_free) begin
      o_valid <= t_valid;
      if (t_adv) begin
        o_res   <= t_out_res;
        o_flags <= t_out_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp16_add_issue.sv
// Testbench for fp16_add_issue: models the external registered adder,
// drives directed and random operand pairs, and scoreboards results in order.
module tb_fp16_add_issue;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  bit   rand_mode = 1'b0;
  logic [19:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [19:0] prev_out = 20'h0;
  logic [15:0] rnd_tab [13];

  fp16_add_issue_if bus ();

  fp16_add_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Same-sign normal fp16 add with truncation; on overflow it returns an
  // exponent of 31 with whatever mantissa bits fell out.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] hi, lo;
    logic [4:0]  d;
    logic [11:0] ma, mb, s;
    logic [5:0]  e;
    if (b[14:10] > a[14:10]) begin hi = b; lo = a; end
    else begin hi = a; lo = b; end
    d  = hi[14:10] - lo[14:10];
    ma = {2'b01, hi[9:0]};
    mb = (d > 5'd11) ? 12'd0 : ({2'b01, lo[9:0]} >> d);
    s  = ma + mb;
    e  = {1'b0, hi[14:10]};
    if (s[11]) begin
      s = s >> 1;
      e = e + 6'd1;
    end
    if (e >= 6'd31) return {a[15], 5'h1F, s[9:0]};
    return {a[15], e[4:0], s[9:0]};
  endfunction

  // External adder: registers its operands every clock, no enable.
  always @(posedge clk) bus.add_x <= fp_add(bus.add_a, bus.add_b);

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
  endfunction

  // Reference classification: returns {flags, result}.
  function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, s;
    logic [3:0]  f;
    x = a;
    y = b;
    f = 4'b0000;
    if (x[14:10] == 5'd0 && x[9:0] != 10'd0) begin x = {x[15], 15'h0}; f[3] = 1'b1; end
    if (y[14:10] == 5'd0 && y[9:0] != 10'd0) begin y = {y[15], 15'h0}; f[3] = 1'b1; end
    if (is_nan(x) || is_nan(y)) return {f | 4'b0001, 16'h7E00};
    if (is_inf(x) && is_inf(y)) begin
      if (x[15] == y[15]) return {f, x};
      return {f | 4'b0001, 16'h7E00};
    end
    if (is_inf(x)) return {f, x};
    if (is_inf(y)) return {f, y};
    if (x[14:0] == 15'd0) begin
      if (y[14:0] == 15'd0) return {f, x[15] & y[15], 15'h0};
      return {f, y};
    end
    if (y[14:0] == 15'd0) return {f, x};
    if (x[15] != y[15]) return {f | 4'b0100, 16'h7E00};
    s = fp_add(x, y);
    if (s[14:10] == 5'h1F) return {f | 4'b0010, s[15], 5'h1F, 10'h000};
    return {f, s};
  endfunction

  // Single comparison point.
  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance to just after the next rising edge; random mode re-rolls out_ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present a pair until accepted; expected value is queued at acceptance.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [19:0] e);
    bit done;
    done = 1'b0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    chk("accept", 20'(done), 20'd1);
  endtask

  task automatic stop_in();
    bus.in_valid = 1'b0;
  endtask

  // Wait for every queued result to come out.
  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) tick();
    chk("drain", 20'(exp_q.size()), 20'd0);
  endtask

  // Check the 2-cycle accept-to-valid latency from just after the accepting edge.
  task automatic check_latency(input string tag);
    @(negedge clk);
    chk({tag, "_e0"}, 20'(bus.out_valid), 20'd0);
    tick();
    @(negedge clk);
    chk({tag, "_e1"}, 20'(bus.out_valid), 20'd0);
    tick();
    @(negedge clk);
    chk({tag, "_e2"}, 20'(bus.out_valid), 20'd1);
  endtask

  // Scoreboard: pop on each output handshake, and check hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {bus.out_flags, bus.out_result}, prev_out);
      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", 20'(exp_q.size() != 0), 20'd1);
        if (exp_q.size() != 0) chk("out_result", {bus.out_flags, bus.out_result}, exp_q.pop_front());
      end
      prev_stall <= bus.out_valid & ~bus.out_ready;
      prev_out   <= {bus.out_flags, bus.out_result};
    end
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rnd_tab = '{16'h3C00, 16'h4000, 16'h4400, 16'hBC00, 16'hC000, 16'h3800, 16'h7BFF,
                16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h8000, 16'h0000};
    // Reset state
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = 16'h0;
    bus.in_b = 16'h0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 20'(bus.out_valid), 20'd0);
    chk("rst_out_result", 20'(bus.out_result), 20'd0);
    chk("rst_out_flags", 20'(bus.out_flags), 20'd0);
    chk("rst_add_a", 20'(bus.add_a), 20'd0);
    chk("rst_add_b", 20'(bus.add_b), 20'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("in_ready_after_rst", 20'(bus.in_ready), 20'd1);
    tick();

    // Single adder-path pair with latency check
    send(16'h3C00, 16'h3C00, {4'b0000, 16'h4000});
    stop_in();
    check_latency("lat");
    drain();

    // Directed classifications, back to back
    send(16'h7BFF, 16'h7BFF, {4'b0010, 16'h7C00});
    send(16'h7C00, 16'hFC00, {4'b0001, 16'h7E00});
    send(16'h7C00, 16'h3C00, {4'b0000, 16'h7C00});
    send(16'h8000, 16'h8000, {4'b0000, 16'h8000});
    send(16'h0001, 16'h3C00, {4'b1000, 16'h3C00});
    send(16'h3C00, 16'hBC00, {4'b0100, 16'h7E00});
    send(16'h0001, 16'h7E01, {4'b1001, 16'h7E00});
    send(16'hFC00, 16'hFC00, {4'b0000, 16'hFC00});
    send(16'h0000, 16'h8000, {4'b0000, 16'h0000});
    send(16'h3C00, 16'h0000, {4'b0000, 16'h3C00});
    stop_in();
    drain();

    // Backpressure: three pairs fill S1/T/O, fourth is refused
    bus.out_ready = 1'b0;
    send(16'h3C00, 16'h3C00, {4'b0000, 16'h4000});
    send(16'h4000, 16'h3C00, {4'b0000, 16'h4200});
    send(16'h4400, 16'h4400, {4'b0000, 16'h4800});
    bus.in_a = 16'h4800;
    bus.in_b = 16'h4000;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("stall_in_ready", 20'(bus.in_ready), 20'd0);
    chk("stall_out_valid", 20'(bus.out_valid), 20'd1);
    chk("stall_head", 20'(bus.out_result), 20'h04000);
    tick();
    bus.out_ready = 1'b1;
    send(16'h4800, 16'h4000, {4'b0000, 16'h4900});
    send(16'h3800, 16'h3800, {4'b0000, 16'h3C00});
    send(16'h4200, 16'h4200, {4'b0000, 16'h4600});
    send(16'hBC00, 16'hBC00, {4'b0000, 16'hC000});
    send(16'hC000, 16'hBC00, {4'b0000, 16'hC200});
    stop_in();
    drain();

    // Mixed random traffic under random out_ready
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = rnd_tab[$urandom_range(0, 12)];
      rb = rnd_tab[$urandom_range(0, 12)];
      send(ra, rb, ref_model(ra, rb));
    end
    stop_in();
    drain();
    rand_mode = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // Reset with three pairs in flight
    bus.out_ready = 1'b0;
    send(16'h3C00, 16'h3C00, {4'b0000, 16'h4000});
    send(16'h4000, 16'h3C00, {4'b0000, 16'h4200});
    send(16'h4400, 16'h4400, {4'b0000, 16'h4800});
    stop_in();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 20'(bus.out_valid), 20'd0);
    exp_q.delete();
    tick();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("rst_mid_in_ready", 20'(bus.in_ready), 20'd1);
    tick();
    send(16'h3C00, 16'h3C00, {4'b0000, 16'h4000});
    stop_in();
    check_latency("post_rst_lat");
    drain();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
